// File: rtl/fm_deviation_shaper_if.sv
// rtl/fm_deviation_shaper_if.sv - sample stream and modulator-side signals of fm_deviation_shaper
interface fm_deviation_shaper_if;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [31:0] phase_inc;
  logic        active;
  logic        clipped;

  modport master (
    output enable, sample_in, sample_valid,
    input  phase_inc, active, clipped
  );

  modport slave (
    input  enable, sample_in, sample_valid,
    output phase_inc, active, clipped
  );
endinterface

// File: rtl/fm_deviation_shaper.sv
// rtl/fm_deviation_shaper.sv - audio sample to slew-limited FM phase increment, with mute timeout
// Optional pre-emphasis is compiled in when PREEMPH_EN is defined.
module fm_deviation_shaper #(
  parameter logic [31:0] BASE_PHASE_INCREMENT = 32'h40000000,
  parameter logic [31:0] DEV_SCALE            = 32'h00009A5E,
  parameter int          EMPH_SHIFT           = 2,
  parameter logic [31:0] MAX_STEP             = 32'h00000400,
  parameter int          TIMEOUT_CYCLES       = 4096
) (
  input logic clk,
  input logic rst_n,
  fm_deviation_shaper_if.slave bus
);

  if (EMPH_SHIFT < 0 || EMPH_SHIFT > 8 || MAX_STEP == 32'd0 ||
      TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("fm_deviation_shaper: parameter out of legal range");
  end

  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {MUTED = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_q, state_d;

  logic               accept;
  logic               timeout_hit;
  logic [15:0]        x_q;
  logic               v0_q;
  logic signed [15:0] y_q;
  logic               v1_q;
  logic               clipped_q;
  logic [31:0]        target_q;
  logic [31:0]        phase_q;
  logic [15:0]        cnt_q;

  logic signed [17:0] y_wide;
  logic signed [15:0] y_sat;
  logic               sat_hit;
  logic [47:0]        prod;
  logic [31:0]        target_new;
  logic signed [32:0] slew_diff;
  logic [32:0]        slew_mag;
  logic [31:0]        phase_next;

  assign accept      = bus.enable & bus.sample_valid;
  assign timeout_hit = (state_q == ACTIVE) && (cnt_q == 16'd0) && !accept;

`ifdef PREEMPH_EN
  logic signed [15:0] x_prev_q;
  logic signed [16:0] diff_x;
  logic signed [16:0] diff_sh;

  always_comb begin
    diff_x  = {x_q[15], x_q} - {x_prev_q[15], x_prev_q};
    diff_sh = diff_x >>> EMPH_SHIFT;
    y_wide  = {{2{x_q[15]}}, x_q} + {diff_sh[16], diff_sh};
  end

  // History restarts from silence after a mute so the first new sample is not over-emphasised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q <= '0;
    end else if (!bus.enable) begin
      x_prev_q <= '0;
    end else if (v0_q) begin
      x_prev_q <= x_q;
    end else if (timeout_hit) begin
      x_prev_q <= '0;
    end
  end
`else
  assign y_wide = {{2{x_q[15]}}, x_q};
`endif

  // Symmetric clamp: -32768 is folded to -32767 so positive and negative deviation match.
  always_comb begin
    sat_hit = 1'b0;
    y_sat   = y_wide[15:0];
    if (y_wide > 18'sd32767) begin
      y_sat   = 16'sd32767;
      sat_hit = 1'b1;
    end else if (y_wide < -18'sd32767) begin
      y_sat   = -16'sd32767;
      sat_hit = 1'b1;
    end
  end

  assign prod       = {{32{y_q[15]}}, y_q} * {16'd0, DEV_SCALE};
  assign target_new = BASE_PHASE_INCREMENT + 32'(prod >> 16);

  always_comb begin
    slew_diff  = {1'b0, target_q} - {1'b0, phase_q};
    slew_mag   = slew_diff[32] ? (~slew_diff + 33'd1) : slew_diff;
    phase_next = target_q;
    if (slew_mag > {1'b0, MAX_STEP}) begin
      phase_next = slew_diff[32] ? (phase_q - MAX_STEP) : (phase_q + MAX_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUTED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = MUTED;
    end else begin
      case (state_q)
        MUTED:   if (v1_q) state_d = ACTIVE;
        ACTIVE:  if (timeout_hit) state_d = MUTED;
        default: state_d = MUTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      v0_q      <= 1'b0;
      y_q       <= '0;
      v1_q      <= 1'b0;
      clipped_q <= 1'b0;
    end else if (!bus.enable) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      clipped_q <= 1'b0;
    end else begin
      v0_q      <= accept;
      v1_q      <= v0_q;
      clipped_q <= v0_q & sat_hit;
      if (accept) x_q <= bus.sample_in;
      if (v0_q)   y_q <= y_sat;
    end
  end

  // Disabling snaps the carrier to centre at once; a timeout only retargets and lets the slew run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= BASE_PHASE_INCREMENT;
      phase_q  <= BASE_PHASE_INCREMENT;
    end else if (!bus.enable) begin
      target_q <= BASE_PHASE_INCREMENT;
      phase_q  <= BASE_PHASE_INCREMENT;
    end else begin
      phase_q <= phase_next;
      if (v1_q) begin
        target_q <= target_new;
      end else if (timeout_hit || state_q == MUTED) begin
        target_q <= BASE_PHASE_INCREMENT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!bus.enable) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= TIMEOUT_LOAD;
    end else if (cnt_q != 16'd0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign bus.phase_inc = phase_q;
  assign bus.active    = (state_q == ACTIVE);
  assign bus.clipped   = clipped_q;

endmodule

// File: tb/tb_fm_deviation_shaper.sv
// tb/tb_fm_deviation_shaper.sv - directed and randomized checks of fm_deviation_shaper
// Reference model tracks per-edge events derived from the block's timing rules.
module tb_fm_deviation_shaper;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] DEV  = 32'h00009A5E;
  localparam logic [31:0] MAXS = 32'h00000400;
  localparam int          TOUT = 16;
`ifdef PREEMPH_EN
  localparam int          SH   = 2;
  localparam bit          EXP_CLIP_MAX = 1'b1;
`else
  localparam bit          EXP_CLIP_MAX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fm_deviation_shaper_if bus ();

  fm_deviation_shaper #(
    .BASE_PHASE_INCREMENT(BASE),
    .DEV_SCALE(DEV),
    .EMPH_SHIFT(2),
    .MAX_STEP(MAXS),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int     e = 0;
  longint m_phase, m_target;
  bit     m_active, m_clip;
  int     m_xprev, last_acc;
  longint tgt_at[int];
  bit     clip_at[int];

  task automatic model_reset();
    m_phase  = BASE;
    m_target = BASE;
    m_active = 0;
    m_clip   = 0;
    m_xprev  = 0;
    last_acc = -100000;
    tgt_at.delete();
    clip_at.delete();
  endtask

  task automatic model_step(input logic en, input logic sv, input logic [15:0] x);
    longint diff, p;
    int     xs, y;
    bit     clp;
    e++;
    if (!en) begin
      model_reset();
      return;
    end
    diff = m_target - m_phase;
    if (diff > longint'(MAXS))       m_phase = m_phase + longint'(MAXS);
    else if (diff < -longint'(MAXS)) m_phase = m_phase - longint'(MAXS);
    else                             m_phase = m_target;
    m_clip = clip_at.exists(e) ? clip_at[e] : 1'b0;
    if (tgt_at.exists(e)) begin
      m_target = tgt_at[e];
      m_active = 1;
    end else if (m_active && !sv && e == last_acc + TOUT) begin
      m_active = 0;
      m_target = BASE;
      m_xprev  = 0;
    end else if (!m_active) begin
      m_target = BASE;
    end
    if (sv) begin
      last_acc = e;
      xs = int'($signed(x));
`ifdef PREEMPH_EN
      y = xs + ((xs - m_xprev) >>> SH);
`else
      y = xs;
`endif
      clp = 0;
      if (y > 32767) begin
        y = 32767;
        clp = 1;
      end else if (y < -32767) begin
        y = -32767;
        clp = 1;
      end
      m_xprev = xs;
      clip_at[e+1] = clp;
      p = longint'(y) * longint'(DEV);
      tgt_at[e+2] = (longint'(BASE) + (p >>> 16)) & 64'h00000000FFFFFFFF;
    end
  endtask

  task automatic drive_edge(input logic en, input logic sv, input logic [15:0] x);
    bus.enable       = en;
    bus.sample_valid = sv;
    bus.sample_in    = x;
    @(posedge clk);
    model_step(en, sv, x);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.phase_inc !== BASE) begin
      n_bad++; $display("FAIL reset_phase got=%h want=%h", bus.phase_inc, BASE);
    end
    n_total++;
    if (bus.active !== 1'b0) begin
      n_bad++; $display("FAIL reset_active got=%b want=0", bus.active);
    end
    n_total++;
    if (bus.clipped !== 1'b0) begin
      n_bad++; $display("FAIL reset_clipped got=%b want=0", bus.clipped);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10000; i++) begin
      drive_edge(1'b1, 1'b0, 16'h0000);
      n_total++;
      if (bus.phase_inc !== BASE || bus.active !== 1'b0 || bus.clipped !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_hold cyc=%0d got=%h/%b/%b want=%h/0/0", i, bus.phase_inc, bus.active, bus.clipped, BASE);
      end
    end
  endtask

  task automatic test_slew();
    drive_edge(1'b0, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'h4000);
    for (int j = 1; j <= 14; j++) begin
      drive_edge(1'b1, 1'b0, 16'h0000);
      n_total++;
      if (bus.active !== (j >= 2)) begin
        n_bad++; $display("FAIL slew_active k+%0d got=%b want=%b", j, bus.active, (j >= 2));
      end
      n_total++;
      if (bus.phase_inc !== m_phase[31:0]) begin
        n_bad++; $display("FAIL slew_model k+%0d got=%h want=%h", j, bus.phase_inc, m_phase[31:0]);
      end
      if (j == 3) begin
        n_total++;
        if (bus.phase_inc !== BASE + MAXS) begin
          n_bad++; $display("FAIL slew_first_step got=%h want=%h", bus.phase_inc, BASE + MAXS);
        end
      end
`ifndef PREEMPH_EN
      if (j == 11) begin
        n_total++;
        if (bus.phase_inc !== 32'h40002400) begin
          n_bad++; $display("FAIL slew_k11 got=%h want=40002400", bus.phase_inc);
        end
      end
      if (j >= 12) begin
        n_total++;
        if (bus.phase_inc !== 32'h40002697) begin
          n_bad++; $display("FAIL slew_settle k+%0d got=%h want=40002697", j, bus.phase_inc);
        end
      end
`endif
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp_ph;
    exp_ph = BASE;
    drive_edge(1'b0, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'h4000);
    for (int j = 1; j <= 30; j++) begin
      drive_edge(1'b1, 1'b0, 16'h0000);
      if (j >= 2) begin
        n_total++;
        if (bus.active !== (j < TOUT)) begin
          n_bad++; $display("FAIL timeout_active k+%0d got=%b want=%b", j, bus.active, (j < TOUT));
        end
      end
      if (j == TOUT) begin
        exp_ph = m_phase[31:0];
      end else if (j > TOUT) begin
        exp_ph = (exp_ph - BASE > MAXS) ? exp_ph - MAXS : BASE;
        n_total++;
        if (bus.phase_inc !== exp_ph) begin
          n_bad++; $display("FAIL timeout_ramp k+%0d got=%h want=%h", j, bus.phase_inc, exp_ph);
        end
      end
    end
    n_total++;
    if (bus.phase_inc !== BASE) begin
      n_bad++; $display("FAIL timeout_centre got=%h want=%h", bus.phase_inc, BASE);
    end
  endtask

  task automatic test_clip();
    drive_edge(1'b0, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'h7FFF);
    drive_edge(1'b1, 1'b0, 16'h0000);
    n_total++;
    if (bus.clipped !== EXP_CLIP_MAX) begin
      n_bad++; $display("FAIL clip_max got=%b want=%b", bus.clipped, EXP_CLIP_MAX);
    end
    drive_edge(1'b1, 1'b0, 16'h0000);
    n_total++;
    if (bus.clipped !== 1'b0) begin
      n_bad++; $display("FAIL clip_pulse_width got=%b want=0", bus.clipped);
    end
    drive_edge(1'b1, 1'b1, 16'h8000);
    drive_edge(1'b1, 1'b0, 16'h0000);
    n_total++;
    if (bus.clipped !== 1'b1) begin
      n_bad++; $display("FAIL clip_min got=%b want=1", bus.clipped);
    end
    for (int j = 2; j <= 14; j++) begin
      drive_edge(1'b1, 1'b0, 16'h0000);
      n_total++;
      if (bus.phase_inc !== m_phase[31:0] || bus.clipped !== 1'b0) begin
        n_bad++; $display("FAIL clip_ramp k+%0d got=%h/%b want=%h/0", j, bus.phase_inc, bus.clipped, m_phase[31:0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    drive_edge(1'b0, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'h4000);
    for (int j = 1; j < TOUT; j++) drive_edge(1'b1, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'hC000);
    n_total++;
    if (bus.active !== 1'b1) begin
      n_bad++; $display("FAIL late_sample_active got=%b want=1", bus.active);
    end
    for (int j = 1; j <= 4; j++) begin
      drive_edge(1'b1, 1'b0, 16'h0000);
      n_total++;
      if (bus.active !== 1'b1 || bus.phase_inc !== m_phase[31:0]) begin
        n_bad++; $display("FAIL late_sample_hold +%0d got=%b/%h want=1/%h", j, bus.active, bus.phase_inc, m_phase[31:0]);
      end
    end
    drive_edge(1'b0, 1'b0, 16'h0000);
    n_total++;
    if (bus.phase_inc !== BASE || bus.active !== 1'b0 || bus.clipped !== 1'b0) begin
      n_bad++; $display("FAIL disable_snap got=%h/%b/%b want=%h/0/0", bus.phase_inc, bus.active, bus.clipped, BASE);
    end
  endtask

  task automatic test_back_to_back();
    drive_edge(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      drive_edge(1'b1, 1'b1, 16'($urandom));
      n_total++;
      if (bus.phase_inc !== m_phase[31:0] || bus.active !== m_active || bus.clipped !== m_clip) begin
        n_bad++;
        $display("FAIL b2b i=%0d got=%h/%b/%b want=%h/%b/%b", i, bus.phase_inc, bus.active, bus.clipped, m_phase[31:0], m_active, m_clip);
      end
    end
  endtask

  task automatic test_random();
    logic        en, sv;
    logic [15:0] x;
    int          gap;
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) != 0);
      if (gap > 0) begin
        gap--;
        sv = 1'b0;
      end else begin
        sv = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 39) == 0) gap = $urandom_range(10, 30);
      end
      case ($urandom_range(0, 7))
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        2:       x = 16'h8001;
        default: x = 16'($urandom);
      endcase
      drive_edge(en, sv, x);
      n_total++;
      if (bus.phase_inc !== m_phase[31:0] || bus.active !== m_active || bus.clipped !== m_clip) begin
        n_bad++;
        $display("FAIL random i=%0d got=%h/%b/%b want=%h/%b/%b", i, bus.phase_inc, bus.active, bus.clipped, m_phase[31:0], m_active, m_clip);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_edge(1'b0, 1'b0, 16'h0000);
    drive_edge(1'b1, 1'b1, 16'h7000);
    repeat (5) drive_edge(1'b1, 1'b0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.phase_inc !== BASE || bus.active !== 1'b0 || bus.clipped !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got=%h/%b/%b want=%h/0/0", bus.phase_inc, bus.active, bus.clipped, BASE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_edge(1'b1, 1'b0, 16'h0000);
    n_total++;
    if (bus.phase_inc !== BASE || bus.active !== 1'b0) begin
      n_bad++; $display("FAIL post_reset got=%h/%b want=%h/0", bus.phase_inc, bus.active, BASE);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_slew();
    test_timeout();
    test_clip();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
